// File: rtl/uart_pkg.sv
// Definitions shared by both ends of the UART link: frame state names,
// line levels and a counter-width helper.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   // A counter for n distinct values never shrinks below one bit, so n=1 stays legal.
   function automatic int counterWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte handshake between a producer and the UART transmitter.
interface uart_transmitter_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Counts CLKS_PER_BIT cycles per bit period and pulses bitEnd on the last one.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic restart_i,
   input  logic enable_i,
   output logic bitEnd_o
);

   localparam int CW = counterWidth(CLKS_PER_BIT);

   logic [CW-1:0] cycleCnt_q;

   assign bitEnd_o = enable_i && (cycleCnt_q == CW'(CLKS_PER_BIT - 1));

   // The count is held at zero whenever the line is idle, so every bit period starts clean.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycleCnt_q <= '0;
      end else if (restart_i || !enable_i || bitEnd_o) begin
         cycleCnt_q <= '0;
      end else begin
         cycleCnt_q <= cycleCnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// UART serializer: start bit, MSB-first payload, stop bits, with a one-byte
// holding register so consecutive frames run with no idle gap.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 1,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   uart_transmitter_if.slave     bus,
   output logic                  tx,
   output logic                  busy
);

   localparam int BW = $clog2(DATA_BITS + 1);
   localparam int SW = counterWidth(STOP_BITS);

   uart_state_e          state_q;
   logic [DATA_BITS-1:0] shiftReg_q;
   logic [DATA_BITS-1:0] holdReg_q;
   logic                 holdFull_q;
   logic [BW-1:0]        bitCnt_q;
   logic [SW-1:0]        stopCnt_q;
   logic                 tx_q;

   logic                 accept;
   logic                 bitEnd;
   logic                 lastData;
   logic                 lastStop;
   logic                 reload;
   logic                 restart;
   logic [DATA_BITS-1:0] shiftNext;
   logic [DATA_BITS-1:0] reloadByte;

   assign bus.ready  = !holdFull_q && !rst;
   assign accept     = bus.valid && bus.ready;
   assign lastData   = (bitCnt_q == BW'(DATA_BITS - 1));
   assign lastStop   = (stopCnt_q == SW'(STOP_BITS - 1));
   // A byte arriving on the final stop cycle is taken straight into the next frame.
   assign reload     = (state_q == STOP) && bitEnd && lastStop && (holdFull_q || accept);
   assign reloadByte = holdFull_q ? holdReg_q : bus.data;
   assign restart    = ((state_q == IDLE) && accept) || reload;
   assign shiftNext  = shiftReg_q << 1;

   assign tx   = tx_q;
   assign busy = (state_q != IDLE);

   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) bitTimer (
      .clk       (clk),
      .rst       (rst),
      .restart_i (restart),
      .enable_i  (state_q != IDLE),
      .bitEnd_o  (bitEnd)
   );

   // Frame sequencer; tx is registered alongside the state so the line never glitches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         shiftReg_q <= '0;
         holdReg_q  <= '0;
         holdFull_q <= 1'b0;
         bitCnt_q   <= '0;
         stopCnt_q  <= '0;
         tx_q       <= IDLE_LEVEL;
      end else begin
         if (accept && (state_q != IDLE)) begin
            holdReg_q  <= bus.data;
            holdFull_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               tx_q <= IDLE_LEVEL;
               if (accept) begin
                  shiftReg_q <= bus.data;
                  state_q    <= START;
                  tx_q       <= START_BIT;
               end
            end
            START: begin
               if (bitEnd) begin
                  state_q  <= DATA;
                  tx_q     <= shiftReg_q[DATA_BITS-1];
                  bitCnt_q <= '0;
               end
            end
            DATA: begin
               if (bitEnd) begin
                  if (lastData) begin
                     state_q   <= STOP;
                     tx_q      <= STOP_BIT;
                     bitCnt_q  <= '0;
                     stopCnt_q <= '0;
                  end else begin
                     shiftReg_q <= shiftNext;
                     tx_q       <= shiftNext[DATA_BITS-1];
                     bitCnt_q   <= bitCnt_q + BW'(1);
                  end
               end
            end
            STOP: begin
               if (bitEnd) begin
                  if (lastStop) begin
                     stopCnt_q <= '0;
                     if (reload) begin
                        shiftReg_q <= reloadByte;
                        holdFull_q <= 1'b0;
                        state_q    <= START;
                        tx_q       <= START_BIT;
                     end else begin
                        state_q <= IDLE;
                        tx_q    <= IDLE_LEVEL;
                     end
                  end else begin
                     stopCnt_q <= stopCnt_q + SW'(1);
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= IDLE_LEVEL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a default instance and a slow, two-stop-bit instance,
// each compared cycle by cycle against line waveforms built from the framing rules.
module tb_uart_transmitter;

   logic clk;
   logic rst;
   logic txA, busyA, txB, busyB;
   int   checks   = 0;
   int   failures = 0;

   uart_transmitter_if #(.DATA_BITS(8)) ifA ();
   uart_transmitter_if #(.DATA_BITS(8)) ifB ();

   uart_transmitter #(
      .DATA_BITS(8), .CLKS_PER_BIT(1), .STOP_BITS(1)
   ) dutA (
      .clk(clk), .rst(rst), .bus(ifA.slave), .tx(txA), .busy(busyA)
   );

   uart_transmitter #(
      .DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(2)
   ) dutB (
      .clk(clk), .rst(rst), .bus(ifB.slave), .tx(txB), .busy(busyB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic txOf(input int sel);
      return (sel != 0) ? txB : txA;
   endfunction

   function automatic logic busyOf(input int sel);
      return (sel != 0) ? busyB : busyA;
   endfunction

   function automatic logic readyOf(input int sel);
      return (sel != 0) ? ifB.ready : ifA.ready;
   endfunction

   task automatic applyStimulus(input int sel, input logic v, input logic [7:0] d);
      if (sel != 0) begin
         ifB.valid = v;
         ifB.data  = d;
      end else begin
         ifA.valid = v;
         ifA.data  = d;
      end
   endtask

   // Feeds bytes as fast as the model says the holding slot allows and checks the
   // line against the concatenation of all expected frames. While the slot is full,
   // 8'hFF is offered and must be refused.
   task automatic streamCheck(input int sel, input logic [7:0] bytes[$]);
      int   cpb      = (sel != 0) ? 4 : 1;
      int   stopBits = (sel != 0) ? 2 : 1;
      int   frameLen = (1 + 8 + stopBits) * cpb;
      logic exp[$];
      int   nb = 0;
      int   k = 0;
      bit   started = 0;
      bit   expReady;
      bit   offered;
      logic [7:0] b;

      foreach (bytes[i]) begin
         b = bytes[i];
         for (int c = 0; c < cpb; c++) exp.push_back(1'b0);
         for (int j = 7; j >= 0; j--)
            for (int c = 0; c < cpb; c++) exp.push_back(b[j]);
         for (int c = 0; c < stopBits * cpb; c++) exp.push_back(1'b1);
      end

      for (int guard = 0; guard < exp.size() + 4; guard++) begin
         if (started && k == exp.size()) break;
         expReady = started ? (nb <= (k / frameLen) + 1) : 1'b1;
         if (started) begin
            checkOutput($sformatf("tx[%0d] sel%0d", k, sel), 32'(txOf(sel)), 32'(exp[k]));
            checkOutput($sformatf("busy[%0d] sel%0d", k, sel), 32'(busyOf(sel)), 32'd1);
            checkOutput($sformatf("ready[%0d] sel%0d", k, sel), 32'(readyOf(sel)), 32'(expReady));
         end
         offered = 0;
         if (nb < bytes.size() && expReady) begin
            applyStimulus(sel, 1'b1, bytes[nb]);
            offered = 1;
         end else if (!expReady) begin
            applyStimulus(sel, 1'b1, 8'hFF);
         end else begin
            applyStimulus(sel, 1'b0, 8'($urandom));
         end
         tick();
         if (offered) nb++;
         if (started) k++;
         else if (offered) begin
            started = 1;
            k = 0;
         end
      end
      applyStimulus(sel, 1'b0, 8'($urandom));
      checkOutput($sformatf("stream length sel%0d", sel), 32'(k), 32'(exp.size()));
      checkOutput($sformatf("idle tx sel%0d", sel), 32'(txOf(sel)), 32'd1);
      checkOutput($sformatf("idle busy sel%0d", sel), 32'(busyOf(sel)), 32'd0);
      checkOutput($sformatf("idle ready sel%0d", sel), 32'(readyOf(sel)), 32'd1);
   endtask

   initial begin
      logic [7:0] q[$];
      int sel, n;

      rst = 1'b1;
      applyStimulus(0, 1'b0, 8'h00);
      applyStimulus(1, 1'b0, 8'h00);
      #1;
      checkOutput("reset tx", 32'(txA), 32'd1);
      checkOutput("reset busy", 32'(busyA), 32'd0);
      checkOutput("reset ready", 32'(ifA.ready), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      checkOutput("release ready", 32'(ifA.ready), 32'd1);
      checkOutput("release tx", 32'(txA), 32'd1);
      checkOutput("release readyB", 32'(ifB.ready), 32'd1);

      q = '{8'hE0};
      streamCheck(0, q);
      q = '{8'hA5, 8'h3C};
      streamCheck(0, q);

      // Data wiggling without valid must never reach the line.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1'b0, 8'($urandom));
         tick();
         checkOutput("unsampled data tx", 32'(txA), 32'd1);
      end

      // Reset in the middle of a frame abandons it immediately.
      applyStimulus(0, 1'b1, 8'h55);
      tick();
      applyStimulus(0, 1'b0, 8'h00);
      tick();
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      checkOutput("midframe reset tx", 32'(txA), 32'd1);
      checkOutput("midframe reset busy", 32'(busyA), 32'd0);
      checkOutput("midframe reset ready", 32'(ifA.ready), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      checkOutput("post reset ready", 32'(ifA.ready), 32'd1);
      checkOutput("post reset tx", 32'(txA), 32'd1);
      checkOutput("post reset busy", 32'(busyA), 32'd0);

      q = '{8'h01};
      streamCheck(0, q);
      q = '{8'h81};
      streamCheck(1, q);
      q = '{8'h81, 8'h7E};
      streamCheck(1, q);

      for (int r = 0; r < 6; r++) begin
         sel = int'($urandom_range(0, 1));
         n   = int'($urandom_range(1, 3));
         q.delete();
         for (int i = 0; i < n; i++) q.push_back(8'($urandom));
         streamCheck(sel, q);
         for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
